// File: rtl/rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_sched_pkg
// Purpose  : State encoding and width helpers shared by the round-robin
//            scheduling blocks.
// Revision : 1.0 - initial release
// ============================================================================
package rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } sched_state_e;

    // Bits needed to index 'value' distinct items; never less than one.
    function automatic int width_of(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next_finder.sv
`default_nettype none
// ============================================================================
// Module   : rr_next_finder
// Purpose  : Rotating-priority search: first set req bit after cur, with
//            wrap-around, cur itself checked last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_next_finder #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  cur,
    output logic [$clog2(N)-1:0]  nxt,
    output logic                  any
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] w_idx;

    // Walk from the farthest offset down so the nearest hit wins; offset N
    // wraps back onto cur, giving it the lowest priority.
    always_comb begin
        nxt   = cur;
        any   = 1'b0;
        w_idx = cur;
        for (int k = N; k >= 1; k--) begin
            w_idx = cur + SW'(k);
            if (req[w_idx]) begin
                nxt = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dwrr_pop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dwrr_pop_scheduler
// Purpose  : Deficit-weighted round-robin pop scheduler for the output FIFO
//            bank. Build option: DEFICIT_CARRY_EN (carry unused credit).
// Revision : 1.0 - initial release
// ============================================================================
module dwrr_pop_scheduler
    import rr_sched_pkg::*;
#(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              enb,
    input  logic [QUEUE_QUANTITY*width_of(MAX_WEIGHT)-1:0]    pesos,
    input  logic [QUEUE_QUANTITY-1:0]                         buf_empty,
    input  logic                                              down_almost_full,
    output logic [QUEUE_QUANTITY-1:0]                         pop,
    output logic [width_of(QUEUE_QUANTITY)-1:0]               selector,
    output logic                                              selector_enb,
    output logic [1:0]                                        sched_state
);

    localparam int WW = width_of(MAX_WEIGHT);
    localparam int SW = width_of(QUEUE_QUANTITY);
`ifdef DEFICIT_CARRY_EN
    localparam int            CW         = WW + 1;
    localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(2*MAX_WEIGHT - 1);
`else
    localparam int            CW         = WW;
`endif

    sched_state_e  state_q, state_d;
    logic [SW-1:0] cur_q, cur_d;
    logic [CW-1:0] credit_q [QUEUE_QUANTITY];
    logic [CW-1:0] credit_d [QUEUE_QUANTITY];

    logic [SW-1:0] w_nxt;
    logic          w_any;
    logic [WW-1:0] w_weight;
    logic [CW-1:0] w_cur_credit;
    logic [CW-1:0] w_load_credit;
    logic          w_issue;
    logic          w_exit;

    rr_next_finder #(
        .N   (QUEUE_QUANTITY)
    ) u_next_finder (
        .req (~buf_empty),
        .cur (cur_q),
        .nxt (w_nxt),
        .any (w_any)
    );

    // A zero weight still earns one pop so the queue cannot starve.
    assign w_weight     = (pesos[cur_q*WW +: WW] == '0) ? WW'(1) : pesos[cur_q*WW +: WW];
    assign w_cur_credit = credit_q[cur_q];

`ifdef DEFICIT_CARRY_EN
    logic [CW:0] w_load_sum;
    assign w_load_sum    = {1'b0, w_cur_credit} + (CW+1)'(w_weight);
    assign w_load_credit = (w_load_sum > CREDIT_MAX) ? CREDIT_MAX[CW-1:0] : w_load_sum[CW-1:0];
`else
    assign w_load_credit = w_cur_credit + CW'(w_weight);
`endif

    assign w_issue = enb && !rst && (state_q == SERVE) && !buf_empty[cur_q] && !down_almost_full;
    assign w_exit  = (w_issue && (w_cur_credit == CW'(1))) || buf_empty[cur_q];

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        if (enb) begin
            unique case (state_q)
                IDLE: begin
                    if (w_any) begin
                        cur_d   = w_nxt;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    credit_d[cur_q] = w_load_credit;
                    state_d         = SERVE;
                end
                SERVE: begin
                    if (w_issue) begin
                        credit_d[cur_q] = w_cur_credit - CW'(1);
                    end
                    if (w_exit) begin
`ifndef DEFICIT_CARRY_EN
                        credit_d[cur_q] = '0;
`endif
                        if (w_any) begin
                            cur_d   = w_nxt;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= SW'(QUEUE_QUANTITY - 1);
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
        end
    end

    always_comb begin
        pop = '0;
        if (w_issue) begin
            pop[cur_q] = 1'b1;
        end
    end

    assign selector     = cur_q;
    assign selector_enb = w_issue;
    assign sched_state  = state_q;

endmodule
`default_nettype wire
